// File: rtl/mult_acc_pipe.sv
// rtl/mult_acc_pipe.sv - three-stage signed multiply-add / multiply-accumulate pipeline
module mult_acc_pipe #(
  parameter int A_DATA_WIDTH = 25,
  parameter int B_DATA_WIDTH = 18,
  parameter int C_DATA_WIDTH = 48,
  parameter int P_DATA_WIDTH = 48,
  parameter int ACC_LEN      = 16,
  parameter int SATURATE     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    mode,
  input  logic                    clr,
  input  logic [A_DATA_WIDTH-1:0] a,
  input  logic [B_DATA_WIDTH-1:0] b,
  input  logic [C_DATA_WIDTH-1:0] c,
  output logic                    out_valid,
  output logic [P_DATA_WIDTH-1:0] p,
  output logic                    overflow
);

  localparam int AB_W  = A_DATA_WIDTH + B_DATA_WIDTH;
  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);
  localparam logic signed [P_DATA_WIDTH-1:0] P_MAX = {1'b0, {(P_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [P_DATA_WIDTH-1:0] P_MIN = {1'b1, {(P_DATA_WIDTH-1){1'b0}}};

  // stage 1
  logic                           s1_valid;
  logic                           s1_mode;
  logic                           s1_clr;
  logic signed [A_DATA_WIDTH-1:0] s1_a;
  logic signed [B_DATA_WIDTH-1:0] s1_b;
  logic signed [P_DATA_WIDTH-1:0] s1_c;

  // stage 2
  logic                           s2_valid;
  logic                           s2_mode;
  logic                           s2_clr;
  logic signed [P_DATA_WIDTH-1:0] s2_prod;
  logic signed [P_DATA_WIDTH-1:0] s2_c;

  // stage 3 state
  logic [CNT_W-1:0]               cnt;
  logic signed [P_DATA_WIDTH-1:0] acc;
  logic                           acc_ovf;

  // product operands widened first so the multiply keeps all A+B bits
  logic signed [AB_W-1:0]         a_ext;
  logic signed [AB_W-1:0]         b_ext;
  logic signed [AB_W-1:0]         prod_ab;

  // stage 3 combinational terms
  logic [CNT_W-1:0]               eff_cnt;
  logic                           start;
  logic                           last;
  logic signed [P_DATA_WIDTH-1:0] addend;
  logic signed [P_DATA_WIDTH-1:0] sum;
  logic signed [P_DATA_WIDTH-1:0] res;
  logic                           add_ovf;
  logic                           frame_ovf;

  assign a_ext   = AB_W'(s1_a);
  assign b_ext   = AB_W'(s1_b);
  assign prod_ab = a_ext * b_ext;

  // stage 1: capture inputs, sign-extend c to the result width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_clr   <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_mode  <= mode;
      s1_clr   <= clr;
      s1_a     <= a;
      s1_b     <= b;
      s1_c     <= P_DATA_WIDTH'($signed(c));
    end
  end

  // stage 2: register the full-precision product, carry c and control alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_mode  <= 1'b0;
      s2_clr   <= 1'b0;
      s2_prod  <= '0;
      s2_c     <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_mode  <= s1_mode;
      s2_clr   <= s1_clr;
      s2_prod  <= P_DATA_WIDTH'(prod_ab);
      s2_c     <= s1_c;
    end
  end

  // stage 3 datapath: clr or a mode-0 sample restarts the frame, so the effective
  // count is 0; a frame's first sample is seeded with c instead of the accumulator
  always_comb begin
    eff_cnt   = (s2_clr || !s2_mode) ? '0 : cnt;
    start     = (eff_cnt == '0);
    last      = !s2_mode || (eff_cnt == CNT_LAST);
    addend    = start ? s2_c : acc;
    sum       = s2_prod + addend;
    add_ovf   = (s2_prod[P_DATA_WIDTH-1] == addend[P_DATA_WIDTH-1]) &&
                (sum[P_DATA_WIDTH-1] != s2_prod[P_DATA_WIDTH-1]);
    res       = sum;
    if ((SATURATE != 0) && add_ovf) begin
      res = addend[P_DATA_WIDTH-1] ? P_MIN : P_MAX;
    end
    frame_ovf = start ? add_ovf : (acc_ovf | add_ovf);
  end

  // stage 3 registers: emit on the last sample of a frame (every sample in mode 0),
  // otherwise fold the sum into the accumulator; bubbles only honour clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      acc_ovf   <= 1'b0;
      p         <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (s2_valid) begin
        if (last) begin
          out_valid <= 1'b1;
          p         <= res;
          overflow  <= frame_ovf;
          cnt       <= '0;
        end else begin
          acc       <= res;
          acc_ovf   <= frame_ovf;
          cnt       <= eff_cnt + CNT_W'(1);
        end
      end else if (s2_clr) begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mult_acc_pipe.sv
// tb/tb_mult_acc_pipe.sv - scoreboard bench for mult_acc_pipe with a transaction-level model
module tb_mult_acc_pipe;

  localparam int ACC = 4;

  typedef struct {
    longint p;
    bit     ov;
    int     cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        mode = 1'b0;
  logic        clr = 1'b0;
  logic [24:0] a = '0;
  logic [17:0] b = '0;
  logic [47:0] c = '0;
  logic [42:0] c_s;

  logic        out_valid0, out_valid1, out_valid2;
  logic [47:0] p0;
  logic [42:0] p1, p2;
  logic        ov0, ov1, ov2;

  int     cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;
  exp_t   q0[$];
  exp_t   q1[$];
  exp_t   q2[$];
  int     mcnt[3];
  longint macc[3];
  bit     mov[3];
  int     pw[3]  = '{48, 43, 43};
  bit     sat[3] = '{1'b0, 1'b1, 1'b0};

  assign c_s = c[42:0];

  mult_acc_pipe #(.A_DATA_WIDTH(25), .B_DATA_WIDTH(18), .C_DATA_WIDTH(48),
                  .P_DATA_WIDTH(48), .ACC_LEN(ACC), .SATURATE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .clr(clr),
    .a(a), .b(b), .c(c), .out_valid(out_valid0), .p(p0), .overflow(ov0));

  mult_acc_pipe #(.A_DATA_WIDTH(25), .B_DATA_WIDTH(18), .C_DATA_WIDTH(43),
                  .P_DATA_WIDTH(43), .ACC_LEN(ACC), .SATURATE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .clr(clr),
    .a(a), .b(b), .c(c_s), .out_valid(out_valid1), .p(p1), .overflow(ov1));

  mult_acc_pipe #(.A_DATA_WIDTH(25), .B_DATA_WIDTH(18), .C_DATA_WIDTH(43),
                  .P_DATA_WIDTH(43), .ACC_LEN(ACC), .SATURATE(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .clr(clr),
    .a(a), .b(b), .c(c_s), .out_valid(out_valid2), .p(p2), .overflow(ov2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // exact sum reduced to a w-bit signed result, either clamped or wrapped
  function automatic longint fold(longint s, int w, bit sa, output bit ov);
    longint one = 1;
    longint mx  = (one <<< (w - 1)) - 1;
    longint mn  = -mx - 1;
    ov = (s > mx) || (s < mn);
    if (!ov) return s;
    if (sa) return (s > mx) ? mx : mn;
    return (s > mx) ? s - (one <<< w) : s + (one <<< w);
  endfunction

  task automatic push(int i, exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic model_step(int i, bit v, bit m, bit cl, longint prod, longint cv);
    longint r;
    bit     ov;
    exp_t   e;
    if (cl) mcnt[i] = 0;
    if (!v) return;
    if (!m) begin
      mcnt[i] = 0;
      r = fold(prod + cv, pw[i], sat[i], ov);
      e = '{r, ov, cyc};
      push(i, e);
      return;
    end
    if (mcnt[i] == 0) begin
      r = fold(prod + cv, pw[i], sat[i], ov);
      mov[i] = ov;
    end else begin
      r = fold(macc[i] + prod, pw[i], sat[i], ov);
      mov[i] = mov[i] | ov;
    end
    macc[i] = r;
    mcnt[i] = mcnt[i] + 1;
    if (mcnt[i] == ACC) begin
      e = '{r, mov[i], cyc};
      push(i, e);
      mcnt[i] = 0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0;
      macc[i] = 0;
      mov[i]  = 1'b0;
    end
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  task automatic drive(bit v, bit m, bit cl, logic [24:0] av, logic [17:0] bv, logic [47:0] cv);
    longint prod;
    longint c48;
    longint c43;
    @(negedge clk);
    in_valid = v;
    mode     = m;
    clr      = cl;
    a        = av;
    b        = bv;
    c        = cv;
    prod = longint'($signed(av)) * longint'($signed(bv));
    c48  = $signed(cv);
    c43  = $signed(cv[42:0]);
    model_step(0, v, m, cl, prod, c48);
    model_step(1, v, m, cl, prod, c43);
    model_step(2, v, m, cl, prod, c43);
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic check_out(int i, longint pv, bit ovv);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (i)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    n_tests++;
    if (!have) begin
      n_fail++;
      $display("FAIL unexpected_out dut%0d cyc=%0d p=%0d ov=%0d", i, cyc, pv, ovv);
    end else if (pv != e.p || ovv != e.ov || (cyc - e.cyc) != 3) begin
      n_fail++;
      $display("FAIL result dut%0d got p=%0d ov=%0d lat=%0d, want p=%0d ov=%0d lat=3",
               i, pv, ovv, cyc - e.cyc, e.p, e.ov);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (out_valid0) check_out(0, $signed(p0), ov0);
      if (out_valid1) check_out(1, $signed(p1), ov1);
      if (out_valid2) check_out(2, $signed(p2), ov2);
    end
  endtask

  task automatic check_zero(string tag);
    n_tests++;
    if ({out_valid0, ov0, p0} != '0) begin
      n_fail++;
      $display("FAIL %s dut0 got v=%0d ov=%0d p=%0d, want all 0", tag, out_valid0, ov0, $signed(p0));
    end
    n_tests++;
    if ({out_valid1, ov1, p1} != '0 || {out_valid2, ov2, p2} != '0) begin
      n_fail++;
      $display("FAIL %s dut1/2 got p1=%0d p2=%0d, want all 0", tag, $signed(p1), $signed(p2));
    end
  endtask

  task automatic check_drained(string tag);
    n_tests++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL %s pending got %0d/%0d/%0d, want 0/0/0", tag, q0.size(), q1.size(), q2.size());
    end
  endtask

  function automatic logic [24:0] ra();
    logic [31:0] t = $urandom;
    return t[24:0];
  endfunction

  function automatic logic [17:0] rb();
    logic [31:0] t = $urandom;
    return t[17:0];
  endfunction

  function automatic logic [47:0] rc();
    logic [63:0] t = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       return 48'h7FFF_FFFF_FFFF;
      1:       return 48'h8000_0000_0000;
      2:       return 48'h03FF_FFFF_FFFF;
      3:       return 48'hFC00_0000_0000;
      4:       return {{8{t[39]}}, t[39:0]};
      default: return t[47:0];
    endcase
  endfunction

  initial begin
    model_reset();
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // mode 0 single sample, then an 8-sample stream
    drive(1, 0, 0, 25'sd3, -18'sd4, 48'sd5);
    for (int i = 0; i < 8; i++) drive(1, 0, 0, ra(), rb(), rc());
    idle(4);

    // mode 1 frame, back to back and with bubbles
    drive(1, 1, 0, 25'sd1, 18'sd1, 48'sd10);
    drive(1, 1, 0, 25'sd2, 18'sd2, 48'sd77);
    drive(1, 1, 0, 25'sd3, 18'sd3, 48'sd77);
    drive(1, 1, 0, 25'sd4, 18'sd4, 48'sd77);
    idle(4);
    drive(1, 1, 0, 25'sd1, 18'sd1, 48'sd10);
    idle(2);
    drive(1, 1, 0, 25'sd2, 18'sd2, 48'sd0);
    idle(1);
    drive(1, 1, 0, 25'sd3, 18'sd3, 48'sd0);
    idle(3);
    drive(1, 1, 0, 25'sd4, 18'sd4, 48'sd0);
    idle(4);

    // clr with a valid sample, then clr on a bubble
    drive(1, 1, 0, 25'sd5, 18'sd5, 48'sd7);
    drive(1, 1, 0, 25'sd5, 18'sd5, 48'sd7);
    drive(1, 1, 1, 25'sd1, 18'sd1, 48'sd0);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 25'sd1, 18'sd1, 48'sd99);
    idle(4);
    drive(1, 1, 0, 25'sd5, 18'sd5, 48'sd7);
    drive(1, 1, 0, 25'sd5, 18'sd5, 48'sd7);
    drive(0, 1, 1, 25'sd0, 18'sd0, 48'sd0);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 25'sd1, 18'sd1, 48'sd3);
    idle(4);

    // overflow at both rails, and a frame whose seed overflows (sticky flag)
    drive(1, 0, 0, 25'sd1, 18'sd1, 48'h03FF_FFFF_FFFF);
    drive(1, 0, 0, -25'sd1, 18'sd1, 48'hFC00_0000_0000);
    drive(1, 1, 0, 25'sd1, 18'sd1, 48'h03FF_FFFF_FFFF);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, -25'sd2, 18'sd3, 48'sd0);
    idle(4);

    // mode switch aborts a half-done frame; next frame starts clean
    drive(1, 1, 0, 25'sd3, 18'sd3, 48'sd0);
    drive(1, 1, 0, 25'sd3, 18'sd3, 48'sd0);
    drive(1, 0, 0, 25'sd2, 18'sd2, 48'sd1);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, ra(), rb(), rc());
    idle(4);

    // two back-to-back frames
    for (int i = 0; i < 8; i++) drive(1, 1, 0, ra(), rb(), rc());
    idle(4);

    // asynchronous reset with samples in flight
    for (int i = 0; i < 3; i++) drive(1, 0, 0, ra(), rb(), rc());
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    clr      = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check_drained("after_reset");
    drive(1, 0, 0, 25'sd100, -18'sd7, 48'sd1000);
    idle(4);

    // randomized mixed traffic
    for (int i = 0; i < 400; i++) begin
      bit v, m, cl;
      v  = ($urandom_range(0, 3) != 0);
      m  = ($urandom_range(0, 15) == 0) ? ~mode : mode;
      cl = ($urandom_range(0, 31) == 0);
      drive(v, m, cl, ra(), rb(), rc());
    end
    idle(6);
    check_drained("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
